unidade_controle: RTL

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 88 ++++++++
 rtl/unidade_controle_if.sv | 33 +++
 rtl/unidade_controle_decod_funct.sv | 31 +++
 rtl/unidade_controle.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// rtl/unidade_controle_pkg.sv - shared encodings for the multicycle MIPS control unit
// Purpose: ALU opCode values (also used by the ALU), MIPS opcode/funct values,
//          datapath select values, FSM state encoding and the registered
//          control-word layout.
// Ports:   none (package).
package unidade_controle_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_OR   = 3'b010,
      ALU_EQ   = 3'b011,
      ALU_LT   = 3'b100,
      ALU_MULT = 3'b101,
      ALU_DIV  = 3'b110,
      ALU_AND  = 3'b111
   } alu_op_t;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_t;

   typedef enum logic [5:0] {
      FN_MULT = 6'b011000,
      FN_DIV  = 6'b011010,
      FN_ADD  = 6'b100000,
      FN_SUB  = 6'b100010,
      FN_AND  = 6'b100100,
      FN_OR   = 6'b100101,
      FN_SLT  = 6'b101010
   } funct_t;

   typedef enum logic [1:0] {
      SRCB_REG = 2'b00,
      SRCB_4   = 2'b01,
      SRCB_IMM = 2'b10
   } src_b_t;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_t;

   typedef enum logic [3:0] {
      INICIO     = 4'd0,
      BUSCA      = 4'd1,
      DECODIFICA = 4'd2,
      EXEC_R     = 4'd3,
      ESCR_R     = 4'd4,
      CALC_END   = 4'd5,
      LE_MEM     = 4'd6,
      ESCR_LW    = 4'd7,
      GRAVA_MEM  = 4'd8,
      EXEC_I     = 4'd9,
      ESCR_I     = 4'd10,
      DESVIO     = 4'd11,
      SALTO      = 4'd12,
      ERRO       = 4'd13
   } estado_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       ior_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] op_code;
      logic       erro;
   } ctrl_t;

   // States that wait on memReady and are covered by the wait counter.
   function automatic logic is_mem_state(input estado_t s);
      return (s == BUSCA) || (s == LE_MEM) || (s == GRAVA_MEM);
   endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// rtl/unidade_controle_if.sv - control unit <-> datapath/memory bundle
// Purpose: groups instruction fields, flags, memory handshake and datapath controls.
// Ports:   master = control unit (drives controls), slave = datapath/memory side.
interface unidade_controle_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       isZero;
   logic       memReady;
   logic       memReq;
   logic       memWrite;
   logic       irWrite;
   logic       pcWrite;
   logic       regWrite;
   logic       regDst;
   logic       memToReg;
   logic       iorD;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] pcSrc;
   logic [2:0] opCode;

   modport master (
      input  opcode, funct, isZero, memReady,
      output memReq, memWrite, irWrite, pcWrite, regWrite, regDst,
             memToReg, iorD, aluSrcA, aluSrcB, pcSrc, opCode
   );

   modport slave (
      output opcode, funct, isZero, memReady,
      input  memReq, memWrite, irWrite, pcWrite, regWrite, regDst,
             memToReg, iorD, aluSrcA, aluSrcB, pcSrc, opCode
   );
endinterface

// File: rtl/unidade_controle_decod_funct.sv
// rtl/unidade_controle_decod_funct.sv - R-type funct to ALU opCode decoder
// Purpose: maps funct to an ALU opCode and flags unsupported functs.
//          Macro MULTDIV_EN adds mult (011000) and div (011010).
// Ports:   funct (in, 6), op_code (out, 3), valid (out, 1).
module decod_funct
   import unidade_controle_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] op_code,
   output logic       valid
);

   always_comb begin
      op_code = ALU_ADD;
      valid   = 1'b1;
      case (funct)
         FN_ADD:  op_code = ALU_ADD;
         FN_SUB:  op_code = ALU_SUB;
         FN_AND:  op_code = ALU_AND;
         FN_OR:   op_code = ALU_OR;
         FN_SLT:  op_code = ALU_LT;
`ifdef MULTDIV_EN
         FN_MULT: op_code = ALU_MULT;
         FN_DIV:  op_code = ALU_DIV;
`else
`endif
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle MIPS control unit (Moore FSM + memory wait counter)
// Purpose: sequences fetch/decode/execute/memory/writeback, faults on bad
//          opcode/funct or memory timeout. Macro MULTDIV_EN enables mult/div functs.
// Ports:   clock, reset (async, active-high); bus (master modport of
//          unidade_controle_if); erro (sticky fault); estado (state, debug).
module unidade_controle
   import unidade_controle_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   unidade_controle_if.master     bus,
   output logic                   erro,
   output logic [3:0]             estado
);

   localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CICLOS - 1);

   estado_t       state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   ctrl_t         ctrl_q, ctrl_d;
   logic [2:0]    r_op;
   logic          r_valid;
   logic          mem_timeout;

   decod_funct u_decod_funct (
      .funct   (bus.funct),
      .op_code (r_op),
      .valid   (r_valid)
   );

   // Control word for a state; r_op only matters in EXEC_R.
   function automatic ctrl_t decode(input estado_t s, input logic [2:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         BUSCA: begin
            c.mem_req   = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = SRCB_4;
         end
         DECODIFICA: c.alu_src_b = SRCB_IMM;
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.op_code   = op;
         end
         ESCR_R: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         CALC_END, EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         LE_MEM: begin
            c.mem_req = 1'b1;
            c.ior_d   = 1'b1;
         end
         ESCR_LW: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         GRAVA_MEM: begin
            c.mem_req   = 1'b1;
            c.ior_d     = 1'b1;
            c.mem_write = 1'b1;
         end
         ESCR_I: c.reg_write = 1'b1;
         DESVIO: begin
            c.alu_src_a = 1'b1;
            c.op_code   = ALU_SUB;
            c.pc_src    = PC_ALUOUT;
         end
         SALTO: begin
            c.pc_src   = PC_JUMP;
            c.pc_write = 1'b1;
         end
         ERRO: c.erro = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      // memReady on the last allowed cycle still counts as completion.
      mem_timeout = is_mem_state(state_q) && !bus.memReady && (wait_q == WAIT_LAST);
      case (state_q)
         INICIO: state_d = BUSCA;
         BUSCA: begin
            if (bus.memReady)   state_d = DECODIFICA;
            else if (mem_timeout) state_d = ERRO;
         end
         DECODIFICA: begin
            case (bus.opcode)
               OP_RTYPE:     state_d = EXEC_R;
               OP_LW, OP_SW: state_d = CALC_END;
               OP_ADDI:      state_d = EXEC_I;
               OP_BEQ:       state_d = DESVIO;
               OP_J:         state_d = SALTO;
               default:      state_d = ERRO;
            endcase
         end
         EXEC_R:   state_d = r_valid ? ESCR_R : ERRO;
         CALC_END: state_d = (bus.opcode == OP_SW) ? GRAVA_MEM : LE_MEM;
         LE_MEM: begin
            if (bus.memReady)   state_d = ESCR_LW;
            else if (mem_timeout) state_d = ERRO;
         end
         GRAVA_MEM: begin
            if (bus.memReady)   state_d = BUSCA;
            else if (mem_timeout) state_d = ERRO;
         end
         EXEC_I: state_d = ESCR_I;
         ESCR_R, ESCR_LW, ESCR_I, DESVIO, SALTO: state_d = BUSCA;
         ERRO:    state_d = ERRO;
         default: state_d = ERRO;
      endcase

      // Every entry into a memory state is a state change, so clearing on
      // any change gives each access a fresh budget.
      if (state_d != state_q)
         wait_d = '0;
      else if (is_mem_state(state_q) && !bus.memReady)
         wait_d = wait_q + 1'b1;

      // Outputs are registered from the next state so they line up with state_q.
      ctrl_d = decode(state_d, r_op);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INICIO;
         wait_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.memReq   = ctrl_q.mem_req;
   assign bus.memWrite = ctrl_q.mem_write;
   assign bus.irWrite  = ctrl_q.ir_write;
   assign bus.regWrite = ctrl_q.reg_write;
   assign bus.regDst   = ctrl_q.reg_dst;
   assign bus.memToReg = ctrl_q.mem_to_reg;
   assign bus.iorD     = ctrl_q.ior_d;
   assign bus.aluSrcA  = ctrl_q.alu_src_a;
   assign bus.aluSrcB  = ctrl_q.alu_src_b;
   assign bus.pcSrc    = ctrl_q.pc_src;
   assign bus.opCode   = ctrl_q.op_code;
   // PC+4 is written only on the fetch-completion cycle; branch writes on zero flag.
   assign bus.pcWrite  = ctrl_q.pc_write
                       | ((state_q == BUSCA)  && bus.memReady)
                       | ((state_q == DESVIO) && bus.isZero);
   assign erro         = ctrl_q.erro;
   assign estado       = state_q;

endmodule
